// File: rtl/pfb_stim_pkg.sv
// Shared constants and types for the PFB/FFT stimulus datapath.
// Frame geometry defaults and the frame arbiter state encoding.
package pfb_stim_pkg;

    localparam int WIDTH        = 16;
    localparam int SAMP_PER_CLK = 2;
    localparam int FFT_LEN      = 64;
    localparam int TDATA_WID    = 2 * SAMP_PER_CLK * WIDTH;
    localparam int BEATS        = FFT_LEN / SAMP_PER_CLK;

    typedef enum logic {
        IDLE,
        STREAM
    } arb_state_t;

endpackage

// File: rtl/stim_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          found
);

    logic [PW-1:0] j;

    // Walk offsets from far to near so the nearest hit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = PW'((int'(ptr) + k) % N);
            if (req[j]) begin
                idx   = j;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stim_frame_arbiter.sv
// Frame-aligned round-robin arbiter for the PFB/FFT test stream.
// Define FRAME_CHECK_EN to build the sticky frame-length checker.
module stim_frame_arbiter
    import pfb_stim_pkg::*;
#(
    parameter int WIDTH        = pfb_stim_pkg::WIDTH,
    parameter int SAMP_PER_CLK = pfb_stim_pkg::SAMP_PER_CLK,
    parameter int FFT_LEN      = pfb_stim_pkg::FFT_LEN,
    parameter int NUM_SRC      = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_SRC-1:0]                        src_en,
    input  logic [NUM_SRC*2*SAMP_PER_CLK*WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]                        s_axis_tvalid,
    output logic [NUM_SRC-1:0]                        s_axis_tready,
    input  logic [NUM_SRC-1:0]                        s_axis_tlast,
    output logic [2*SAMP_PER_CLK*WIDTH-1:0]           m_axis_tdata,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic                                      m_axis_tlast,
    output logic [$clog2(NUM_SRC)-1:0]                grant,
    output logic                                      busy,
    output logic                                      frame_err
);

    localparam int TW = 2 * SAMP_PER_CLK * WIDTH;
    localparam int NB = FFT_LEN / SAMP_PER_CLK;
    localparam int GW = $clog2(NUM_SRC);

    arb_state_t    state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] pick_idx;
    logic          pick_found;
    logic          hs;
    logic          end_frame;

    rr_pick #(
        .N  (NUM_SRC),
        .PW (GW)
    ) u_pick (
        .req   (src_en & s_axis_tvalid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign busy = (state == STREAM);

    // Zero-latency pass-through; everything is gated off while idle.
    always_comb begin
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        if (busy) begin
            s_axis_tready[grant] = m_axis_tready;
            m_axis_tvalid        = s_axis_tvalid[grant];
            m_axis_tdata         = s_axis_tdata[grant*TW +: TW];
            m_axis_tlast         = s_axis_tlast[grant];
        end
    end

    assign hs        = m_axis_tvalid & m_axis_tready;
    assign end_frame = hs & m_axis_tlast;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= pick_idx;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (end_frame) begin
                        rr_ptr <= (grant == GW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FRAME_CHECK_EN
    localparam int CW = $clog2(NB);

    logic [CW-1:0] beat_cnt;
    logic          err_q;

    // Any beat whose tlast disagrees with "last slot of the frame" is an error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == IDLE && pick_found) begin
            beat_cnt <= '0;
        end else if (hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (m_axis_tlast != (beat_cnt == CW'(NB - 1)))
                err_q <= 1'b1;
        end
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_stim_frame_arbiter.sv
// Directed scoreboard bench for stim_frame_arbiter (two sources).
// Expected beats are queued per frame and popped on output handshakes.
module tb_stim_frame_arbiter;
    import pfb_stim_pkg::*;

    localparam int NS = 2;
    localparam int TW = TDATA_WID;
    localparam int BT = BEATS;
`ifdef FRAME_CHECK_EN
    localparam logic FC = 1'b1;
`else
    localparam logic FC = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NS-1:0]    src_en;
    logic [NS*TW-1:0] s_tdata;
    logic [NS-1:0]    s_tvalid;
    logic [NS-1:0]    s_tready;
    logic [NS-1:0]    s_tlast;
    logic [TW-1:0]    m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic [0:0]       grant;
    logic             busy;
    logic             frame_err;

    always #5 clk = ~clk;

    stim_frame_arbiter #(
        .WIDTH        (WIDTH),
        .SAMP_PER_CLK (SAMP_PER_CLK),
        .FFT_LEN      (FFT_LEN),
        .NUM_SRC      (NS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_en        (src_en),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .grant         (grant),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    typedef struct {
        logic [TW-1:0] data;
        logic          last;
        int            src;
    } exp_t;

    exp_t q[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   s_beat[NS];
    int   s_frame[NS];
    int   s_len[NS];
    int   s_stop[NS];
    logic s_on[NS];
    logic bp;
    logic trig;
    logic gap_chk;

    function automatic logic [TW-1:0] mk(int src, int fr, int b);
        return {8'(src), 8'(fr), 16'(b), 16'h0, (b == 0) ? 16'd64 : 16'd0};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            s_tvalid[i]          = s_on[i];
            s_tdata[i*TW +: TW]  = mk(i, s_frame[i], s_beat[i]);
            s_tlast[i]           = (s_beat[i] == s_len[i] - 1);
        end
    endtask

    task automatic push_frame(int src, int fr, int len);
        for (int b = 0; b < len; b++)
            q.push_back('{mk(src, fr, b), (b == len - 1), src});
    endtask

    task automatic cyc();
        logic [NS-1:0] sh;
        exp_t e;
        @(negedge clk);
        if (gap_chk) chk("gap_idle", 64'(busy), 64'(0));
        gap_chk = 1'b0;
        if (busy) begin
            for (int i = 0; i < NS; i++)
                if (i != int'(grant)) chk("other_ready", 64'(s_tready[i]), 64'(0));
        end
        if (m_tvalid && m_tready) begin
            if (q.size() == 0) begin
                ntests++;
                nfail++;
                $error("FAIL extra_beat: observed %0h expected none", m_tdata);
            end else begin
                e = q.pop_front();
                chk("tdata", m_tdata, e.data);
                chk("tlast", 64'(m_tlast), 64'(e.last));
                chk("grant", 64'(grant), 64'(e.src));
            end
            gap_chk = m_tlast;
        end
        sh = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (sh[i]) begin
                if (s_beat[i] == s_len[i] - 1) begin
                    s_beat[i] = 0;
                    s_frame[i]++;
                    if (s_frame[i] == s_stop[i]) s_on[i] = 1'b0;
                end else begin
                    s_beat[i]++;
                end
            end
        end
        if (trig && s_frame[0] == 0 && s_beat[0] == 10) begin
            src_en = 2'b10;
            trig   = 1'b0;
        end
        if (bp) m_tready = 1'($urandom_range(0, 1));
        drive();
    endtask

    task automatic run(string tag, int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            cyc();
            n++;
        end
        if (q.size() > 0) begin
            ntests++;
            nfail++;
            $error("FAIL %s_timeout: observed %0d pending expected 0", tag, q.size());
        end
        repeat (3) cyc();
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_busy"},     64'(busy),      64'(0));
        chk({tag, "_grant"},    64'(grant),     64'(0));
        chk({tag, "_mvalid"},   64'(m_tvalid),  64'(0));
        chk({tag, "_mlast"},    64'(m_tlast),   64'(0));
        chk({tag, "_sready"},   64'(s_tready),  64'(0));
        chk({tag, "_frameerr"}, 64'(frame_err), 64'(0));
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        bp       = 1'b0;
        trig     = 1'b0;
        gap_chk  = 1'b0;
        m_tready = 1'b1;
        src_en   = '0;
        for (int i = 0; i < NS; i++) begin
            s_beat[i]  = 0;
            s_frame[i] = 0;
            s_len[i]   = BT;
            s_stop[i]  = 1;
            s_on[i]    = 1'b0;
        end
        q.delete();
        drive();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b1;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        do_reset();

        // alternation: 0,1,0,1
        s_stop = '{2, 2};
        s_on   = '{1'b1, 1'b1};
        src_en = 2'b11;
        drive();
        push_frame(0, 0, BT);
        push_frame(1, 0, BT);
        push_frame(0, 1, BT);
        push_frame(1, 1, BT);
        run("alt", 400);

        // single enabled source, other valid but masked
        do_reset();
        s_stop = '{3, 1};
        s_on   = '{1'b1, 1'b1};
        src_en = 2'b01;
        drive();
        push_frame(0, 0, BT);
        push_frame(0, 1, BT);
        push_frame(0, 2, BT);
        run("single", 400);
        chk("single_frameerr", 64'(frame_err), 64'(0));

        // random backpressure
        do_reset();
        s_stop = '{2, 2};
        s_on   = '{1'b1, 1'b1};
        src_en = 2'b11;
        bp     = 1'b1;
        drive();
        push_frame(0, 0, BT);
        push_frame(1, 0, BT);
        push_frame(0, 1, BT);
        push_frame(1, 1, BT);
        run("bp", 2000);

        // enable drop mid-frame
        do_reset();
        s_stop = '{2, 1};
        s_on   = '{1'b1, 1'b1};
        src_en = 2'b11;
        trig   = 1'b1;
        drive();
        push_frame(0, 0, BT);
        push_frame(1, 0, BT);
        run("endrop", 400);
        repeat (4) cyc();
        chk("endrop_noregrant", 64'(busy), 64'(0));
        chk("endrop_src0_valid", 64'(s_tvalid[0]), 64'(1));

        // short frame (tlast at beat 20)
        do_reset();
        s_len  = '{21, BT};
        s_on   = '{1'b1, 1'b1};
        src_en = 2'b11;
        drive();
        push_frame(0, 0, 21);
        push_frame(1, 0, BT);
        run("short", 400);
        chk("short_frameerr", 64'(frame_err), 64'(FC));

        // long frame (33 beats)
        do_reset();
        s_len  = '{BT + 1, BT};
        s_on   = '{1'b1, 1'b0};
        src_en = 2'b01;
        drive();
        push_frame(0, 0, BT + 1);
        run("long", 400);
        chk("long_frameerr", 64'(frame_err), 64'(FC));

        // reset asserted at beat 15
        do_reset();
        s_on   = '{1'b1, 1'b1};
        src_en = 2'b11;
        drive();
        push_frame(0, 0, BT);
        n = 0;
        while (s_beat[0] != 15 && n < 100) begin
            cyc();
            n++;
        end
        chk("midrst_reached", 64'(s_beat[0]), 64'(15));
        chk("midrst_busy_before", 64'(busy), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        chk_reset("midrst");
        do_reset();
        s_on   = '{1'b1, 1'b1};
        src_en = 2'b11;
        drive();
        push_frame(0, 0, BT);
        push_frame(1, 0, BT);
        run("postrst", 400);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
